// File: rtl/egress_sched_pkg.sv
// -----------------------------------------------------------------------------
// egress_sched_pkg
// Shared definitions for the egress round-robin scheduler:
//   NPORT, PTR_W, DATA_W : port count and FIFO word widths
//   state_t / ST_*       : scheduler FSM state codes
//   len_field()          : extracts the byte-length field from a pointer word
// -----------------------------------------------------------------------------
package egress_sched_pkg;

    localparam int NPORT  = 4;
    localparam int PTR_W  = 16;
    localparam int DATA_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_PTR   = 3'd1;
    localparam state_t ST_LEN   = 3'd2;
    localparam state_t ST_DATA  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_GAP   = 3'd5;

    // Keeps only the low len_w bits of a pointer word; upper bits carry
    // metadata this block does not interpret.
    function automatic logic [PTR_W-1:0] len_field(input logic [PTR_W-1:0] word,
                                                   input int unsigned      len_w);
        logic [PTR_W-1:0] mask;
        mask = (len_w >= PTR_W) ? '1 : ((PTR_W'(1) << len_w) - PTR_W'(1));
        return word & mask;
    endfunction

endpackage

// File: rtl/egress_rr_sched_rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
// Combinational 4-way round-robin next-grant selector. The search starts at
// last+1 and wraps, so the most recently served port has lowest priority.
//   req   [3:0] in  : request per port (non-empty pointer FIFO)
//   last  [1:0] in  : port granted most recently
//   valid       out : at least one request present
//   grant [1:0] out : selected port (holds 'last' when valid is 0)
// -----------------------------------------------------------------------------
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] grant
);

    logic [1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise the tool infers a latch.
        valid = 1'b0;
        grant = last;
        idx   = last;
        // Walk from the farthest candidate (last+4) to the nearest (last+1);
        // the final write therefore belongs to the nearest requester.
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/egress_rr_sched.sv
// -----------------------------------------------------------------------------
// egress_rr_sched
// Drains four per-port output queues (pointer FIFO + byte FIFO) onto a single
// 8-bit transmit line. Round-robin between non-empty pointer FIFOs; each grant
// pops one pointer, reads L bytes, frames them with tx_sof/tx_dv and then
// holds an inter-frame gap of IFG_CYCLES idle cycles.
//
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   ptr_fifo_empty[3:0]       : pointer FIFO i empty
//   ptr_fifo_dout0..3 [15:0]  : pointer words, valid the cycle after rd
//   ptr_fifo_rd[3:0]          : one-hot pointer pop strobe
//   data_fifo_dout0..3 [7:0]  : data bytes, valid the cycle after rd
//   data_fifo_rd[3:0]         : one-hot byte read strobe
//   tx_pause                  : blocks new grants (looked at in IDLE only)
//   tx_sof, tx_dv, tx_dout    : transmit framing and byte
//   tx_port[1:0]              : source port, stable from grant to end of gap
//   busy                      : FSM not in IDLE
//   frame_cnt0..3, zero_len_cnt : statistics, only with EGRESS_RR_SCHED_STATS_EN
//
// Optional feature macro: EGRESS_RR_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module egress_rr_sched
    import egress_sched_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NPORT-1:0]  ptr_fifo_empty,
    input  logic [PTR_W-1:0]  ptr_fifo_dout0,
    input  logic [PTR_W-1:0]  ptr_fifo_dout1,
    input  logic [PTR_W-1:0]  ptr_fifo_dout2,
    input  logic [PTR_W-1:0]  ptr_fifo_dout3,
    output logic [NPORT-1:0]  ptr_fifo_rd,
    input  logic [DATA_W-1:0] data_fifo_dout0,
    input  logic [DATA_W-1:0] data_fifo_dout1,
    input  logic [DATA_W-1:0] data_fifo_dout2,
    input  logic [DATA_W-1:0] data_fifo_dout3,
    output logic [NPORT-1:0]  data_fifo_rd,
    input  logic              tx_pause,
    output logic              tx_sof,
    output logic              tx_dv,
    output logic [DATA_W-1:0] tx_dout,
    output logic [1:0]        tx_port,
`ifdef EGRESS_RR_SCHED_STATS_EN
    output logic [31:0]       frame_cnt0,
    output logic [31:0]       frame_cnt1,
    output logic [31:0]       frame_cnt2,
    output logic [31:0]       frame_cnt3,
    output logic [15:0]       zero_len_cnt,
`endif
    output logic              busy
);

    localparam bit         NO_GAP = (IFG_CYCLES == 0);
    localparam logic [7:0] IFG_LD = 8'(IFG_CYCLES);

    logic [PTR_W-1:0]  ptr_dout  [NPORT];
    logic [DATA_W-1:0] data_dout [NPORT];

    assign ptr_dout[0]  = ptr_fifo_dout0;
    assign ptr_dout[1]  = ptr_fifo_dout1;
    assign ptr_dout[2]  = ptr_fifo_dout2;
    assign ptr_dout[3]  = ptr_fifo_dout3;
    assign data_dout[0] = data_fifo_dout0;
    assign data_dout[1] = data_fifo_dout1;
    assign data_dout[2] = data_fifo_dout2;
    assign data_dout[3] = data_fifo_dout3;

    state_t            state;
    logic [1:0]        rr_last;
    logic [LEN_W-1:0]  byte_cnt;
    logic [7:0]        gap_cnt;
    logic              drain_ph;
    logic              first_rd;
    logic              dv_p1;
    logic              sof_p1;

    logic              arb_valid;
    logic [1:0]        arb_grant;
    logic [LEN_W-1:0]  frame_len;
    logic [NPORT-1:0]  port_onehot;
    logic              data_rd_any;
    logic              zero_len_err;

    rr_arb4 u_arb (
        .req   (~ptr_fifo_empty),
        .last  (rr_last),
        .valid (arb_valid),
        .grant (arb_grant)
    );

    // The pointer word popped in PTR is on the FIFO output during LEN.
    assign frame_len    = LEN_W'(len_field(ptr_dout[tx_port], LEN_W));
    assign port_onehot  = NPORT'(1) << tx_port;
    assign data_rd_any  = (state == ST_DATA);
    assign zero_len_err = (state == ST_LEN) && (frame_len == '0);

    assign ptr_fifo_rd  = (state == ST_PTR) ? port_onehot : '0;
    assign data_fifo_rd = data_rd_any ? port_onehot : '0;
    assign busy         = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Scheduler FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state    <= ST_IDLE;
            rr_last  <= 2'd3;
            tx_port  <= 2'd0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            drain_ph <= 1'b0;
            first_rd <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!tx_pause && arb_valid) begin
                        state   <= ST_PTR;
                        tx_port <= arb_grant;
                        rr_last <= arb_grant;
                    end
                end
                ST_PTR: begin
                    state <= ST_LEN;
                end
                ST_LEN: begin
                    byte_cnt <= frame_len;
                    first_rd <= 1'b1;
                    if (frame_len != '0) begin
                        state <= ST_DATA;
                    end else if (NO_GAP) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= IFG_LD;
                    end
                end
                ST_DATA: begin
                    first_rd <= 1'b0;
                    byte_cnt <= byte_cnt - LEN_W'(1);
                    if (byte_cnt == LEN_W'(1)) begin
                        state    <= ST_DRAIN;
                        drain_ph <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: the last byte is still in the FIFO read and
                    // tx_dout register stages.
                    drain_ph <= ~drain_ph;
                    if (drain_ph) begin
                        if (NO_GAP) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= IFG_LD;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transmit pipeline: rd -> FIFO output -> tx_dout register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_p1   <= 1'b0;
            sof_p1  <= 1'b0;
            tx_dv   <= 1'b0;
            tx_sof  <= 1'b0;
            tx_dout <= '0;
        end else begin
            dv_p1  <= data_rd_any;
            sof_p1 <= data_rd_any && first_rd;
            tx_dv  <= dv_p1;
            tx_sof <= sof_p1;
            if (dv_p1) begin
                tx_dout <= data_dout[tx_port];
            end
        end
    end

`ifdef EGRESS_RR_SCHED_STATS_EN
    logic [31:0] frame_cnt [NPORT];

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: this array is a handful of counter flops, not a RAM macro,
        // so it takes the reset like any other register.
        if (!rstn) begin
            for (int p = 0; p < NPORT; p++) begin
                frame_cnt[p] <= '0;
            end
            zero_len_cnt <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (tx_sof && (tx_port == 2'(p))) begin
                    frame_cnt[p] <= frame_cnt[p] + 32'd1;
                end
            end
            if (zero_len_err && (zero_len_cnt != 16'hFFFF)) begin
                zero_len_cnt <= zero_len_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt0 = frame_cnt[0];
    assign frame_cnt1 = frame_cnt[1];
    assign frame_cnt2 = frame_cnt[2];
    assign frame_cnt3 = frame_cnt[3];
`else
    // Zero-length pointers are flagged internally only in this build.
    logic unused_zero_len_err;
    assign unused_zero_len_err = zero_len_err;
`endif

endmodule

// File: tb/tb_egress_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_egress_rr_sched
// Self-checking bench for egress_rr_sched. Behavioural FIFOs feed the DUT; a
// negedge monitor logs pointer pops and transmitted frames; a queue-based
// model predicts grant order, frame contents and grant-to-grant spacing.
// -----------------------------------------------------------------------------
module tb_egress_rr_sched;

    localparam int IFG  = 12;
    localparam int LENW = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tx_pause;
    logic        flush_req;
    logic [3:0]  ptr_fifo_empty;
    logic [3:0]  ptr_fifo_rd;
    logic [3:0]  data_fifo_rd;
    logic [15:0] ptr_dout_q  [4];
    logic [7:0]  data_dout_q [4];
    logic        tx_sof, tx_dv, busy;
    logic [7:0]  tx_dout;
    logic [1:0]  tx_port;
`ifdef EGRESS_RR_SCHED_STATS_EN
    logic [31:0] frame_cnt0, frame_cnt1, frame_cnt2, frame_cnt3;
    logic [15:0] zero_len_cnt;
`endif

    int n_pass;
    int n_total;

    always #5 clk = ~clk;

    egress_rr_sched #(.IFG_CYCLES(IFG), .LEN_W(LENW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ptr_fifo_empty  (ptr_fifo_empty),
        .ptr_fifo_dout0  (ptr_dout_q[0]),
        .ptr_fifo_dout1  (ptr_dout_q[1]),
        .ptr_fifo_dout2  (ptr_dout_q[2]),
        .ptr_fifo_dout3  (ptr_dout_q[3]),
        .ptr_fifo_rd     (ptr_fifo_rd),
        .data_fifo_dout0 (data_dout_q[0]),
        .data_fifo_dout1 (data_dout_q[1]),
        .data_fifo_dout2 (data_dout_q[2]),
        .data_fifo_dout3 (data_dout_q[3]),
        .data_fifo_rd    (data_fifo_rd),
        .tx_pause        (tx_pause),
        .tx_sof          (tx_sof),
        .tx_dv           (tx_dv),
        .tx_dout         (tx_dout),
        .tx_port         (tx_port),
`ifdef EGRESS_RR_SCHED_STATS_EN
        .frame_cnt0      (frame_cnt0),
        .frame_cnt1      (frame_cnt1),
        .frame_cnt2      (frame_cnt2),
        .frame_cnt3      (frame_cnt3),
        .zero_len_cnt    (zero_len_cnt),
`endif
        .busy            (busy)
    );

    // ---------------- behavioural output FIFOs ----------------
    logic [15:0] pmem [4][64];
    logic [7:0]  dmem [4][256];
    int          pwr [4];
    int          prd [4];
    int          dwr [4];
    int          drd [4];

    always_comb begin
        ptr_fifo_empty = '0;
        for (int i = 0; i < 4; i++) ptr_fifo_empty[i] = (pwr[i] == prd[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush_req) begin
                prd[i] <= pwr[i];
                drd[i] <= dwr[i];
            end else begin
                if (ptr_fifo_rd[i]) begin
                    ptr_dout_q[i] <= pmem[i][prd[i] % 64];
                    prd[i]        <= prd[i] + 1;
                end
                if (data_fifo_rd[i]) begin
                    data_dout_q[i] <= dmem[i][drd[i] % 256];
                    drd[i]         <= drd[i] + 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          cyc;
    int          np, nf, n_drd, multi_rd, rd_empty, sof_wo_dv;
    int          pop_cyc [64];
    int          pop_port[64];
    int          f_port  [64];
    int          f_cyc   [64];
    int          f_len   [64];
    logic [7:0]  f_bytes [64][16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if ($countones({ptr_fifo_rd, data_fifo_rd}) > 1) multi_rd++;
        if ((ptr_fifo_rd & ptr_fifo_empty) != 4'd0) rd_empty++;
        if (ptr_fifo_rd != 4'd0) begin
            pop_cyc[np % 64]  = cyc;
            pop_port[np % 64] = onehot_idx(ptr_fifo_rd);
            np++;
        end
        if (data_fifo_rd != 4'd0) n_drd++;
        if (tx_sof && !tx_dv) sof_wo_dv++;
        if (tx_dv) begin
            if (tx_sof) begin
                f_port[nf % 64] = int'(tx_port);
                f_cyc[nf % 64]  = cyc;
                f_len[nf % 64]  = 0;
                nf++;
            end
            if (nf > 0) begin
                f_bytes[(nf-1) % 64][f_len[(nf-1) % 64] % 16] = tx_dout;
                f_len[(nf-1) % 64]++;
            end
        end
    end

    // ---------------- reference model ----------------
    int         mq_len  [4][$];
    logic [7:0] mq_bytes[4][$];
    int         model_last;

    // Round-robin rule: first pending port after the last one served.
    function automatic int model_grant(input int last, input bit [3:0] pend);
        for (int k = 1; k <= 4; k++) if (pend[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic load(input int p, input int len, input bit fixed);
        logic [15:0] w;
        logic [7:0]  b;
        for (int i = 0; i < len; i++) begin
            b = fixed ? 8'(8'hA1 + i) : 8'($urandom);
            dmem[p][dwr[p] % 256] = b;
            dwr[p] = dwr[p] + 1;
            mq_bytes[p].push_back(b);
        end
        w = {4'($urandom), 12'(len)};
        pmem[p][pwr[p] % 64] = w;
        pwr[p] = pwr[p] + 1;
        mq_len[p].push_back(len);
    endtask

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            mq_len[p].delete();
            mq_bytes[p].delete();
        end
        model_last = 3;
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || ptr_fifo_empty != 4'hF) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (n >= 3000) begin
            n_total++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, required idle", tag, busy, n);
        end
    endtask

    // Compares logged pops/frames in [from_np, np) / [from_nf, nf) with the model.
    task automatic score(input string tag, input int from_np, input int from_nf, input bit spacing);
        int fi, g, len, prev_gap, got;
        bit [3:0] pend;
        logic [7:0] eb;
        fi = from_nf;
        prev_gap = 0;
        for (int k = from_np; k < np; k++) begin
            for (int p = 0; p < 4; p++) pend[p] = (mq_len[p].size() > 0);
            g = model_grant(model_last, pend);
            n_total++;
            if (pop_port[k % 64] !== g)
                $display("FAIL %s_grant[%0d]: port %0d, required %0d", tag, k - from_np, pop_port[k % 64], g);
            else n_pass++;
            if (g < 0) continue;
            len = mq_len[g].pop_front();
            model_last = g;
            if (spacing && k > from_np) begin
                got = pop_cyc[k % 64] - pop_cyc[(k-1) % 64];
                n_total++;
                if (got !== prev_gap)
                    $display("FAIL %s_spacing[%0d]: %0d cycles, required %0d", tag, k - from_np, got, prev_gap);
                else n_pass++;
            end
            prev_gap = (len == 0) ? IFG + 3 : len + IFG + 5;
            if (len > 0) begin
                n_total++;
                if (fi >= nf) begin
                    $display("FAIL %s_frame_missing[%0d]: no frame, required port %0d len %0d", tag, k - from_np, g, len);
                    for (int i = 0; i < len; i++) eb = mq_bytes[g].pop_front();
                end else begin
                    n_pass++;
                    n_total += 3;
                    if (f_port[fi % 64] !== g)
                        $display("FAIL %s_tx_port[%0d]: %0d, required %0d", tag, fi - from_nf, f_port[fi % 64], g);
                    else n_pass++;
                    if (f_cyc[fi % 64] - pop_cyc[k % 64] !== 4)
                        $display("FAIL %s_sof_latency[%0d]: %0d cycles after pop, required 4", tag, fi - from_nf, f_cyc[fi % 64] - pop_cyc[k % 64]);
                    else n_pass++;
                    if (f_len[fi % 64] !== len)
                        $display("FAIL %s_frame_len[%0d]: %0d bytes, required %0d", tag, fi - from_nf, f_len[fi % 64], len);
                    else n_pass++;
                    for (int i = 0; i < len; i++) begin
                        eb = mq_bytes[g].pop_front();
                        n_total++;
                        if (f_bytes[fi % 64][i % 16] !== eb)
                            $display("FAIL %s_byte[%0d][%0d]: %02h, required %02h", tag, fi - from_nf, i, f_bytes[fi % 64][i % 16], eb);
                        else n_pass++;
                    end
                    fi++;
                end
            end
        end
        n_total++;
        if (nf !== fi) $display("FAIL %s_frame_count: %0d frames, required %0d", tag, nf - from_nf, fi - from_nf);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; tx_pause = 1'b0; flush_req = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        n_total++;
        if ({tx_sof, tx_dv, tx_dout, tx_port, busy, ptr_fifo_rd, data_fifo_rd} !== 21'd0)
            $display("FAIL reset_outputs: sof=%0b dv=%0b dout=%02h port=%0d busy=%0b prd=%b drd=%b, required all 0",
                     tx_sof, tx_dv, tx_dout, tx_port, busy, ptr_fifo_rd, data_fifo_rd);
        else n_pass++;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int s_np, s_nf, s_drd;
        s_np = np; s_nf = nf; s_drd = n_drd;
        load(2, 4, 1'b1);
        wait_quiet("single");
        n_total++;
        if (n_drd - s_drd !== 4) $display("FAIL single_data_rd: %0d reads, required 4", n_drd - s_drd);
        else n_pass++;
        score("single", s_np, s_nf, 1'b0);
    endtask

    task automatic test_rr_order();
        int s_np, s_nf;
        s_np = np; s_nf = nf;
        for (int r = 0; r < 2; r++) for (int p = 0; p < 4; p++) load(p, 1, 1'b0);
        wait_quiet("rr");
        n_total++;
        if (np - s_np !== 8) $display("FAIL rr_pop_count: %0d pops, required 8", np - s_np);
        else n_pass++;
        score("rr", s_np, s_nf, 1'b1);
    endtask

    task automatic test_zero_len();
        int s_np, s_nf, s_drd;
        s_np = np; s_nf = nf; s_drd = n_drd;
        load(1, 0, 1'b0);
        load(1, 2, 1'b0);
        wait_quiet("zero_len");
        n_total++;
        if (n_drd - s_drd !== 2) $display("FAIL zero_len_data_rd: %0d reads, required 2", n_drd - s_drd);
        else n_pass++;
        score("zero_len", s_np, s_nf, 1'b1);
    endtask

    task automatic test_pause();
        int s_np, s_nf, s_drd, n;
        tx_pause = 1'b1;
        load(3, 8, 1'b0);
        load(0, 5, 1'b0);
        s_np = np; s_nf = nf; s_drd = n_drd;
        repeat (50) @(negedge clk);
        n_total++;
        if ((np - s_np) + (n_drd - s_drd) !== 0)
            $display("FAIL pause_idle: %0d pops %0d reads, required 0", np - s_np, n_drd - s_drd);
        else n_pass++;
        tx_pause = 1'b0;
        n = 0;
        while (np == s_np && n < 20) begin @(negedge clk); #1; n++; end
        tx_pause = 1'b1;
        n_total++;
        if (n >= 20) $display("FAIL pause_release: no grant in %0d cycles, required one", n);
        else n_pass++;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        n_total++;
        if (np - s_np !== 1) $display("FAIL pause_hold: %0d pops, required 1", np - s_np);
        else n_pass++;
        score("pause_a", s_np, s_nf, 1'b0);
        s_np = np; s_nf = nf;
        tx_pause = 1'b0;
        wait_quiet("pause_b");
        score("pause_b", s_np, s_nf, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int s_np, s_nf, n;
        s_nf = nf;
        load(1, 10, 1'b0);
        n = 0;
        while (!(nf > s_nf && f_len[(nf-1) % 64] >= 3) && n < 100) begin @(negedge clk); #1; n++; end
        rstn = 1'b0;
        #1;
        n_total++;
        if (n >= 100 || {tx_sof, tx_dv, tx_dout, tx_port, busy, ptr_fifo_rd, data_fifo_rd} !== 21'd0)
            $display("FAIL reset_mid_outputs: wait=%0d dv=%0b dout=%02h port=%0d busy=%0b drd=%b, required all 0",
                     n, tx_dv, tx_dout, tx_port, busy, data_fifo_rd);
        else n_pass++;
        flush_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_req = 1'b0;
        model_clear();
        load(3, 2, 1'b0);
        load(1, 3, 1'b0);
        s_np = np; s_nf = nf;
        @(negedge clk);
        rstn = 1'b1;
        wait_quiet("reset_mid");
        score("reset_mid", s_np, s_nf, 1'b1);
    endtask

    task automatic test_random();
        int s_np, s_nf;
        s_np = np; s_nf = nf;
        for (int i = 0; i < 14; i++) load($urandom_range(0, 3), $urandom_range(0, 6), 1'b0);
        wait_quiet("random");
        score("random", s_np, s_nf, 1'b1);
    endtask

`ifdef EGRESS_RR_SCHED_STATS_EN
    task automatic test_stats();
        int s_np, s_nf;
        @(negedge clk);
        rstn = 1'b0;
        model_clear();
        @(negedge clk);
        n_total++;
        if ({frame_cnt0, frame_cnt1, frame_cnt2, frame_cnt3, zero_len_cnt} !== 144'd0)
            $display("FAIL stats_reset: cnt0=%0d cnt3=%0d zl=%0d, required 0", frame_cnt0, frame_cnt3, zero_len_cnt);
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        s_np = np; s_nf = nf;
        for (int i = 0; i < 5; i++) load(0, $urandom_range(1, 4), 1'b0);
        for (int i = 0; i < 3; i++) load(3, $urandom_range(1, 4), 1'b0);
        load(1, 0, 1'b0);
        wait_quiet("stats");
        score("stats", s_np, s_nf, 1'b1);
        n_total += 5;
        if (frame_cnt0 !== 32'd5) $display("FAIL stats_frame_cnt0: %0d, required 5", frame_cnt0); else n_pass++;
        if (frame_cnt1 !== 32'd0) $display("FAIL stats_frame_cnt1: %0d, required 0", frame_cnt1); else n_pass++;
        if (frame_cnt2 !== 32'd0) $display("FAIL stats_frame_cnt2: %0d, required 0", frame_cnt2); else n_pass++;
        if (frame_cnt3 !== 32'd3) $display("FAIL stats_frame_cnt3: %0d, required 3", frame_cnt3); else n_pass++;
        if (zero_len_cnt !== 16'd1) $display("FAIL stats_zero_len_cnt: %0d, required 1", zero_len_cnt); else n_pass++;
    endtask
`endif

    task automatic test_protocol();
        n_total += 3;
        if (multi_rd !== 0) $display("FAIL proto_onehot_rd: %0d cycles with >1 rd, required 0", multi_rd); else n_pass++;
        if (rd_empty !== 0) $display("FAIL proto_rd_empty: %0d pops of empty FIFO, required 0", rd_empty); else n_pass++;
        if (sof_wo_dv !== 0) $display("FAIL proto_sof_dv: %0d sof without dv, required 0", sof_wo_dv); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_single_frame();
        test_rr_order();
        test_zero_len();
        test_pause();
        test_reset_mid_frame();
        test_random();
`ifdef EGRESS_RR_SCHED_STATS_EN
        test_stats();
`endif
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
